// File: rtl/esn7e_demo_nios2_qsys_oci_dct_packer.sv
// OCI direct-compressed-trace producer: packs 2-bit trace codes into 30-bit frames
// and hands them downstream over valid/ready, with end-of-test flush tracking.
module esn7e_demo_nios2_qsys_oci_dct_packer #(
  parameter int unsigned MAX_CODES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        code_valid,
  input  logic [1:0]  code,
  input  logic        flush,
  input  logic        frame_ready,
  output logic        frame_valid,
  output logic [29:0] frame_data,
  output logic [3:0]  frame_count,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic [7:0]  drop_count,
  output logic        test_ending,
  output logic        test_has_ended
);

  localparam int unsigned BUF_W  = 30;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DROP_W = 8;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_CODES);

  typedef enum logic {ST_RUN = 1'b0, ST_ENDING = 1'b1} state_t;

  state_t             state;
  logic               flush_pend;
  logic               slot_free;
  logic               transfer;
  logic               accept;
  logic               pack;
  logic               drop;
  logic [CNT_W-1:0]   base_cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [BUF_W-1:0]   base_buf;
  logic [BUF_W-1:0]   buf_nxt;
  logic [CNT_W:0]     slot_lsb;

  assign test_ending = flush_pend;

  // Transfer empties the accumulator first so a same-cycle code lands in slot 0.
  always_comb begin
    flush_pend = (state == ST_ENDING);
    slot_free  = !frame_valid || frame_ready;
    transfer   = ((dct_count == MAX_CNT) || (flush_pend && (dct_count != '0))) && slot_free;
    accept     = code_valid && !flush_pend;
    base_buf   = transfer ? '0 : dct_buffer;
    base_cnt   = transfer ? '0 : dct_count;
    pack       = accept && (base_cnt != MAX_CNT);
    drop       = accept && (base_cnt == MAX_CNT);
    slot_lsb   = {base_cnt, 1'b0};
    buf_nxt    = base_buf;
    cnt_nxt    = base_cnt;
    if (pack) begin
      buf_nxt[slot_lsb +: 2] = code;
      cnt_nxt                = base_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_RUN;
      frame_valid    <= 1'b0;
      frame_data     <= '0;
      frame_count    <= '0;
      dct_buffer     <= '0;
      dct_count      <= '0;
      drop_count     <= '0;
      test_has_ended <= 1'b0;
    end else begin
      dct_buffer <= buf_nxt;
      dct_count  <= cnt_nxt;

      if (transfer) begin
        frame_data  <= dct_buffer;
        frame_count <= dct_count;
        frame_valid <= 1'b1;
      end else if (frame_valid && frame_ready) begin
        frame_valid <= 1'b0;
      end

      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + DROP_W'(1);
      end

      // ENDING is terminal; it only drains and reports when fully empty.
      case (state)
        ST_RUN: begin
          if (flush) state <= ST_ENDING;
        end
        ST_ENDING: begin
          if ((dct_count == '0) && !frame_valid) test_has_ended <= 1'b1;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule
